// File: rtl/expr_pkg.sv
// rtl/expr_pkg.sv - shared constants, field layout tables and FSM state for the field unpacker
//
// Purpose: single source for the packed-vector layout. Fields repeat a
// six-entry pattern of widths {4,5,6,4,5,6}. The first three fields of each
// group are unsigned and the last three are signed. Field 0 sits at the MSB
// end of the vector.
// Ports: none (package).
package expr_pkg;

  localparam int NUM_FIELDS = 18;
  localparam int Y_W        = 90;
  localparam int IDX_W      = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  // Width table: indexed by k mod 6.
  function automatic int field_width(input int k);
    case (k % 6)
      0, 3:    return 4;
      1, 4:    return 5;
      default: return 6;
    endcase
  endfunction

  // Offset table: LSB position of field k. Fields are packed downward from the top bit.
  function automatic int field_lsb(input int k, input int y_w);
    int pos;
    pos = y_w;
    for (int i = 0; i <= k; i++) begin
      pos -= field_width(i);
    end
    return pos;
  endfunction

  function automatic logic field_signed(input int k);
    return ((k % 6) >= 3);
  endfunction

endpackage

// File: rtl/expr_field_extract.sv
// rtl/expr_field_extract.sv - selects one packed field by index and extends it to 8 bits
//
// Purpose: purely combinational. Every field is sliced and extended in parallel,
// and the index then picks one of the results.
// Ports:
//   vec  [Y_W-1:0] in  : captured packed vector
//   idx  [4:0]     in  : field index
//   data [7:0]     out : field value, sign- or zero-extended; 0 for an out-of-range index
module expr_field_extract #(
  parameter int NUM_FIELDS = expr_pkg::NUM_FIELDS,
  parameter int Y_W        = expr_pkg::Y_W
) (
  input  logic [Y_W-1:0] vec,
  input  logic [4:0]     idx,
  output logic [7:0]     data
);
  import expr_pkg::*;

  logic [NUM_FIELDS-1:0][7:0] ext;

  for (genvar k = 0; k < NUM_FIELDS; k++) begin : g_field
    localparam int W = field_width(k);
    localparam int L = field_lsb(k, Y_W);
    logic [W-1:0] f;
    assign f = vec[L +: W];
    if (field_signed(k)) begin : g_signed
      assign ext[k] = {{(8-W){f[W-1]}}, f};
    end else begin : g_unsigned
      assign ext[k] = {{(8-W){1'b0}}, f};
    end
  end

  always_comb begin
    data = 8'h00;
    for (int i = 0; i < NUM_FIELDS; i++) begin
      if (idx == IDX_W'(i)) begin
        data = ext[i];
      end
    end
  end

endmodule

// File: rtl/expr_field_unpacker.sv
// rtl/expr_field_unpacker.sv - streams the fields of a packed result vector one per handshake
//
// Purpose: captures a packed vector and emits fields 0 to NUM_FIELDS-1 in order.
// It keeps a rotating XOR signature of the emitted data and counts completed vectors.
// While the last field is being taken, the block accepts the next vector.
// This gives back-to-back vectors with no idle cycle between them.
// Ports:
//   clk, rst_n                  : clock, synchronous active-low reset
//   in_valid/in_ready/in_y      : input vector handshake
//   out_valid/out_ready         : output field handshake
//   out_idx/out_data/out_last   : current field index, extended value, last-field flag
//   sig                         : running signature of emitted fields
//   vec_cnt                     : number of fully emitted vectors (wraps)
module expr_field_unpacker #(
  parameter int NUM_FIELDS = expr_pkg::NUM_FIELDS,
  parameter int Y_W        = expr_pkg::Y_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [Y_W-1:0] in_y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [4:0]     out_idx,
  output logic [7:0]     out_data,
  output logic           out_last,
  output logic [15:0]    sig,
  output logic [15:0]    vec_cnt
);
  import expr_pkg::*;

  localparam logic [4:0] LAST_IDX = 5'(NUM_FIELDS - 1);

  state_t         state, state_nx;
  logic [4:0]     idx, idx_nx;
  logic [Y_W-1:0] vec_q, vec_nx;
  logic [15:0]    sig_nx, cnt_nx;
  logic [7:0]     field_data;
  logic           emit;

  expr_field_extract #(
    .NUM_FIELDS (NUM_FIELDS),
    .Y_W        (Y_W)
  ) u_extract (
    .vec  (vec_q),
    .idx  (idx),
    .data (field_data)
  );

  assign emit      = (state == ST_EMIT);
  assign out_valid = emit;
  assign out_idx   = idx;
  assign out_last  = emit && (idx == LAST_IDX);
  assign out_data  = emit ? field_data : 8'h00;
  // The next vector is accepted only as the final field leaves.
  assign in_ready  = emit ? (out_last & out_ready) : 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      idx     <= '0;
      vec_q   <= '0;
      sig     <= '0;
      vec_cnt <= '0;
    end else begin
      state   <= state_nx;
      idx     <= idx_nx;
      vec_q   <= vec_nx;
      sig     <= sig_nx;
      vec_cnt <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    vec_nx   = vec_q;
    sig_nx   = sig;
    cnt_nx   = vec_cnt;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          vec_nx   = in_y;
          idx_nx   = '0;
          state_nx = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          sig_nx = {sig[14:0], sig[15]} ^ {8'h00, out_data};
          if (out_last) begin
            cnt_nx = vec_cnt + 16'd1;
            idx_nx = '0;
            if (in_valid) begin
              vec_nx   = in_y;
              state_nx = ST_EMIT;
            end else begin
              state_nx = ST_IDLE;
            end
          end else begin
            idx_nx = idx + 5'd1;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_expr_field_unpacker.sv
// tb/tb_expr_field_unpacker.sv - self-checking bench for expr_field_unpacker
module tb_expr_field_unpacker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [89:0] in_y;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_idx;
  logic [7:0]  out_data;
  logic        out_last;
  logic [15:0] sig;
  logic [15:0] vec_cnt;

  int checks = 0;
  int errors = 0;
  logic [15:0] m_sig = 16'h0;
  logic [15:0] m_cnt = 16'h0;

  always #5 clk = ~clk;

  expr_field_unpacker dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_y      (in_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_data  (out_data),
    .out_last  (out_last),
    .sig       (sig),
    .vec_cnt   (vec_cnt)
  );

  function automatic int w_of(input int k);
    int r;
    case (k % 6)
      0, 3:    r = 4;
      1, 4:    r = 5;
      default: r = 6;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] ref_field(input logic [89:0] v, input int k);
    int top;
    int w;
    logic [7:0] r;
    top = 89;
    for (int i = 0; i < k; i++) top -= w_of(i);
    w = w_of(k);
    r = 8'h00;
    for (int b = 0; b < w; b++) r[b] = v[top - w + 1 + b];
    if ((k % 6) >= 3) for (int b = w; b < 8; b++) r[b] = r[w-1];
    return r;
  endfunction

  function automatic logic [15:0] sig_step(input logic [15:0] s, input logic [7:0] d);
    return {s[14:0], s[15]} ^ {8'h00, d};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; in_y = '0; out_ready = 1'b0;
    tick; tick;
    rst_n = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_idx !== 5'd0) begin errors++; $display("FAIL reset_out_idx got %0d want 0", out_idx); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h want 00", out_data); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b want 0", out_last); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (sig !== 16'h0) begin errors++; $display("FAIL reset_sig got %h want 0000", sig); end
    checks++; if (vec_cnt !== 16'h0) begin errors++; $display("FAIL reset_vec_cnt got %h want 0000", vec_cnt); end
    m_sig = 16'h0; m_cnt = 16'h0;
  endtask

  task automatic test_zero;
    in_valid = 1'b1; in_y = '0; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL zero_idle_ready got %b want 1", in_ready); end
    tick;
    in_valid = 1'b0;
    for (int k = 0; k < 18; k++) begin
      #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL zero_valid k=%0d got %b want 1", k, out_valid); end
      checks++; if (out_idx !== 5'(k)) begin errors++; $display("FAIL zero_idx got %0d want %0d", out_idx, k); end
      checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL zero_data k=%0d got %h want 00", k, out_data); end
      checks++; if (out_last !== (k == 17)) begin errors++; $display("FAIL zero_last k=%0d got %b want %b", k, out_last, (k == 17)); end
      m_sig = sig_step(m_sig, 8'h00);
      if (k == 17) m_cnt++;
      tick;
    end
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL zero_end_valid got %b want 0", out_valid); end
    checks++; if (vec_cnt !== 16'd1) begin errors++; $display("FAIL zero_vec_cnt got %0d want 1", vec_cnt); end
    checks++; if (sig !== 16'h0) begin errors++; $display("FAIL zero_sig got %h want 0000", sig); end
  endtask

  task automatic test_sign;
    logic [89:0] v;
    logic [7:0]  e;
    v = '0; v[89:86] = 4'b1000; v[74:71] = 4'b1000;
    in_valid = 1'b1; in_y = v; out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    for (int k = 0; k < 18; k++) begin
      #1;
      e = (k == 0) ? 8'h08 : (k == 3) ? 8'hF8 : 8'h00;
      checks++; if (out_idx !== 5'(k)) begin errors++; $display("FAIL sign_idx got %0d want %0d", out_idx, k); end
      checks++; if (out_data !== e) begin errors++; $display("FAIL sign_data k=%0d got %h want %h", k, out_data, e); end
      m_sig = sig_step(m_sig, e);
      if (k == 17) m_cnt++;
      tick;
    end
    #1;
    checks++; if (sig !== m_sig) begin errors++; $display("FAIL sign_sig got %h want %h", sig, m_sig); end
    checks++; if (vec_cnt !== m_cnt) begin errors++; $display("FAIL sign_vec_cnt got %0d want %0d", vec_cnt, m_cnt); end
  endtask

  task automatic test_all_ones;
    logic [7:0] e;
    in_valid = 1'b1; in_y = {90{1'b1}}; out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    for (int k = 0; k < 18; k++) begin
      #1;
      case (k % 6)
        0: e = 8'h0F;
        1: e = 8'h1F;
        2: e = 8'h3F;
        default: e = 8'hFF;
      endcase
      checks++; if (out_data !== e) begin errors++; $display("FAIL ones_data k=%0d got %h want %h", k, out_data, e); end
      m_sig = sig_step(m_sig, e);
      if (k == 17) m_cnt++;
      tick;
    end
    #1;
    checks++; if (sig !== m_sig) begin errors++; $display("FAIL ones_sig got %h want %h", sig, m_sig); end
    checks++; if (vec_cnt !== m_cnt) begin errors++; $display("FAIL ones_vec_cnt got %0d want %0d", vec_cnt, m_cnt); end
  endtask

  task automatic test_back_to_back;
    logic [89:0] va, vb, v;
    int k;
    va = 90'h2A5_1234_5678_9ABC_DEF0_1357;
    vb = 90'h15A_FEDC_BA98_7654_3210_2468;
    in_valid = 1'b1; in_y = va; out_ready = 1'b1;
    tick;
    in_y = vb;  // changes while in_ready is low and must not disturb the captured vector
    for (int c = 0; c < 36; c++) begin
      if (c == 18) in_valid = 1'b0;
      #1;
      k = c % 18;
      v = (c < 18) ? va : vb;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid c=%0d got %b want 1", c, out_valid); end
      checks++; if (out_idx !== 5'(k)) begin errors++; $display("FAIL b2b_idx c=%0d got %0d want %0d", c, out_idx, k); end
      checks++; if (out_data !== ref_field(v, k)) begin errors++; $display("FAIL b2b_data c=%0d got %h want %h", c, out_data, ref_field(v, k)); end
      checks++; if (in_ready !== (k == 17)) begin errors++; $display("FAIL b2b_in_ready c=%0d got %b want %b", c, in_ready, (k == 17)); end
      m_sig = sig_step(m_sig, ref_field(v, k));
      if (k == 17) m_cnt++;
      tick;
    end
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_valid got %b want 0", out_valid); end
    checks++; if (sig !== m_sig) begin errors++; $display("FAIL b2b_sig got %h want %h", sig, m_sig); end
    checks++; if (vec_cnt !== m_cnt) begin errors++; $display("FAIL b2b_vec_cnt got %0d want %0d", vec_cnt, m_cnt); end
  endtask

  task automatic test_stall;
    logic [89:0] v;
    int k;
    int cyc;
    v = 90'h3C3_0F0F_A5A5_5A5A_C3C3_9999;
    k = 0; cyc = 0;
    in_valid = 1'b1; in_y = v; out_ready = 1'b0;
    tick;
    in_valid = 1'b0;
    while (k < 18 && cyc < 300) begin
      out_ready = 1'($urandom_range(0, 1));
      #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid cyc=%0d got %b want 1", cyc, out_valid); end
      checks++; if (out_idx !== 5'(k)) begin errors++; $display("FAIL stall_idx cyc=%0d got %0d want %0d", cyc, out_idx, k); end
      checks++; if (out_data !== ref_field(v, k)) begin errors++; $display("FAIL stall_data cyc=%0d got %h want %h", cyc, out_data, ref_field(v, k)); end
      if (out_ready) begin
        m_sig = sig_step(m_sig, ref_field(v, k));
        if (k == 17) m_cnt++;
        k++;
      end
      cyc++;
      tick;
    end
    checks++; if (k != 18) begin errors++; $display("FAIL stall_timeout fields got %0d want 18", k); end
    out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_end_valid got %b want 0", out_valid); end
    checks++; if (sig !== m_sig) begin errors++; $display("FAIL stall_sig got %h want %h", sig, m_sig); end
    checks++; if (vec_cnt !== m_cnt) begin errors++; $display("FAIL stall_vec_cnt got %0d want %0d", vec_cnt, m_cnt); end
  endtask

  task automatic test_mid_reset;
    logic [89:0] vd, ve;
    vd = 90'h0AB_CDEF_0123_4567_89AB_CDEF;
    ve = 90'h301_8000_7FFF_0001_FFFE_4242;
    in_valid = 1'b1; in_y = vd; out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    for (int k = 0; k < 9; k++) tick;
    #1;
    checks++; if (out_idx !== 5'd9) begin errors++; $display("FAIL mrst_pre_idx got %0d want 9", out_idx); end
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    m_sig = 16'h0; m_cnt = 16'h0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mrst_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mrst_in_ready got %b want 1", in_ready); end
    checks++; if (sig !== 16'h0) begin errors++; $display("FAIL mrst_sig got %h want 0000", sig); end
    checks++; if (vec_cnt !== 16'h0) begin errors++; $display("FAIL mrst_vec_cnt got %0d want 0", vec_cnt); end
    in_valid = 1'b1; in_y = ve;
    tick;
    in_valid = 1'b0;
    for (int k = 0; k < 18; k++) begin
      #1;
      checks++; if (out_idx !== 5'(k)) begin errors++; $display("FAIL mrst_idx got %0d want %0d", out_idx, k); end
      checks++; if (out_data !== ref_field(ve, k)) begin errors++; $display("FAIL mrst_data k=%0d got %h want %h", k, out_data, ref_field(ve, k)); end
      m_sig = sig_step(m_sig, ref_field(ve, k));
      if (k == 17) m_cnt++;
      tick;
    end
    #1;
    checks++; if (sig !== m_sig) begin errors++; $display("FAIL mrst_end_sig got %h want %h", sig, m_sig); end
    checks++; if (vec_cnt !== 16'd1) begin errors++; $display("FAIL mrst_end_vec_cnt got %0d want 1", vec_cnt); end
  endtask

  initial begin
    test_reset;
    test_zero;
    test_sign;
    test_all_ones;
    test_back_to_back;
    test_stall;
    test_mid_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/expr_field_unpacker.md
EXPR_FIELD_UNPACKER -- requirements
Module: expr_field_unpacker

Interface
REQ-001 The block SHALL have parameter NUM_FIELDS, default 18, giving the number of packed result fields per vector.
REQ-002 The block SHALL have parameter Y_W, default 90, giving the packed vector width.
REQ-003 The block SHALL use one clock; reset is synchronous and active-low.
REQ-004 Port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1 bit: synchronous active-low reset.
REQ-006 Port in_valid, input, 1 bit: in_y holds a packed result vector.
REQ-007 Port in_ready, output, 1 bit: block accepts in_y this cycle.
REQ-008 Port in_y, input, Y_W bits: packed vector {y0,...,y17}, with y0 at bits [89:86].
REQ-009 Port out_valid, output, 1 bit: out_idx and out_data hold a field.
REQ-010 Port out_ready, input, 1 bit: consumer takes the field this cycle.
REQ-011 Port out_idx, output, 5 bits: field index, 0 to 17.
REQ-012 Port out_data, output, 8 bits: field value, extended to 8 bits.
REQ-013 Port out_last, output, 1 bit: the current field is index 17.
REQ-014 Port sig, output, 16 bits: running signature of all emitted fields.
REQ-015 Port vec_cnt, output, 16 bits: count of fully emitted vectors.

Function
REQ-016 Field k SHALL have width 4, 5 or 6 bits for k mod 6 equal to 0/3, 1/4 or 2/5 respectively.
REQ-017 Field k SHALL be signed when k mod 6 is 3 or greater, and unsigned otherwise.
REQ-018 Field k SHALL occupy the next-lower bits after field k-1, starting from bit 89, so that y17 ends at bit 0.
REQ-019 out_data SHALL be the field sign-extended to 8 bits when the field is signed, and zero-extended when it is unsigned.
REQ-020 The FSM SHALL have two states: IDLE and EMIT.
REQ-021 In IDLE, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-022 On an IDLE handshake (in_valid and in_ready), the block SHALL capture in_y, set the field index to 0 and go to EMIT.
REQ-023 The first field SHALL appear on out_valid the cycle after capture (latency 1).
REQ-024 In EMIT, out_valid SHALL be 1; out_idx, out_data and out_last SHALL be held stable until out_valid and out_ready are both high.
REQ-025 On an output handshake with out_last = 0, the field index SHALL increment by 1.
REQ-026 While out_ready is held high, the block SHALL emit one field per cycle, with no bubbles between fields.
REQ-027 In EMIT, in_ready SHALL equal out_last AND out_ready, so that the next vector is captured in the same cycle that field 17 is taken (zero-bubble back-to-back).
REQ-028 On the last handshake, the block SHALL go to EMIT at index 0 with the new vector if in_valid is high, and to IDLE otherwise.
REQ-029 On the last handshake, vec_cnt SHALL increment, wrapping modulo 2^16.
REQ-030 On each output handshake, sig SHALL be updated to {sig[14:0],sig[15]} XOR {8'h00,out_data}.
REQ-031 in_y SHALL be ignored whenever in_ready is 0.
REQ-032 in_valid asserted while in EMIT with out_last = 0 SHALL have no effect.

Reset
REQ-033 When rst_n is 0 at a clock edge, the FSM SHALL go to IDLE, the index to 0, the captured vector to 0, and sig and vec_cnt to 0.
REQ-034 Immediately after reset: out_valid = 0, out_idx = 0, out_data = 0, out_last = 0, in_ready = 1.
REQ-035 Reset asserted mid-vector SHALL discard the remaining fields, and no partial vec_cnt increment SHALL occur.

Structure
REQ-036 Package expr_pkg SHALL hold NUM_FIELDS, Y_W, the per-field width and offset tables, the signedness function, and the FSM state enum.
REQ-037 Combinational field selection and extension SHALL live in one sub-module, expr_field_extract (inputs: vector and index; output: 8-bit data).
REQ-038 The FSM, capture register, signature and counter SHALL live in expr_field_unpacker.

Verification
REQ-039 After reset, drive in_y = 90'h0 with out_ready = 1 -> 18 fields, idx 0..17, all data 0x00, out_last only at idx 17, vec_cnt = 1, sig = 0.
REQ-040 Drive in_y with only bits [89:86] = 4'b1000 and [74:71] = 4'b1000 -> idx0 data 0x08, idx3 data 0xF8 (sign-extended), all other fields 0x00.
REQ-041 Drive two vectors back-to-back with in_valid held and out_ready = 1 -> 36 consecutive out_valid cycles with no gap, and in_ready pulses exactly at each idx 17.
REQ-042 Toggle out_ready randomly for one vector -> no field lost or duplicated, and idx/data stable throughout every stall.
REQ-043 Assert rst_n = 0 at idx 9 -> next cycle out_valid = 0, in_ready = 1, sig = 0, vec_cnt = 0; a fresh vector then emits from idx 0.
REQ-044 Drive in_y = all ones -> unsigned fields 0x0F, 0x1F, 0x3F and signed fields 0xFF; sig matches the reference model after 18 handshakes.
